pcileech_ft601_emu: RTL and testbench
=====================================

Name: pcileech_ft601_emu

Overview:
- Synthesizable device-side model of the FT601 245 synchronous FIFO interface. It is the responder that the FPGA-side FT601 master in pcileech_com talks to.
- Used in block-level simulation and in on-chip self-test builds, where it replaces the physical FT601 chip.
- A host-side valid/ready stream injects words that the FPGA reads (RX direction). Words the FPGA writes come out on a second host-side stream (TX direction).
- Also drives the rxf_n/txe_n flags and counts protocol errors.

Parameters:
- RX_DEPTH_LOG2, 10: RX FIFO depth is 2^N words (host->FPGA).
- TX_DEPTH_LOG2, 10: TX FIFO depth is 2^N words (FPGA->host).
- TXE_MARGIN, 4: ft601_txe_n goes high once TX free entries <= TXE_MARGIN. This models the real FT601 flag lag.

Ports:
- clk  in  1  single clock, the ft601_clk domain.
- rst  in  1  synchronous, active-high reset.
- host_rx_data  in  32  word to queue for FPGA reads.
- host_rx_valid  in  1  host_rx_data valid.
- host_rx_ready  out  1  RX FIFO can accept.
- host_tx_data  out  32  word written by FPGA.
- host_tx_valid  out  1  host_tx_data valid.
- host_tx_ready  in  1  consumer accepts.
- ft601_data_i  in  32  bus value driven by FPGA.
- ft601_data_o  out  32  bus value driven by emulator.
- ft601_data_oe  out  1  emulator drives data bus.
- ft601_be_i  in  4  byte enables from FPGA.
- ft601_be_o  out  4  byte enables from emulator.
- ft601_rxf_n  out  1  low = RX data available.
- ft601_txe_n  out  1  low = TX space available.
- ft601_rd_n  in  1  read strobe.
- ft601_oe_n  in  1  output enable.
- ft601_wr_n  in  1  write strobe.
- ft601_rst_n  in  1  low = flush both FIFOs.
- ft601_siwu_n  in  1  ignored.
- rx_level  out  RX_DEPTH_LOG2+1  RX occupancy.
- tx_level  out  TX_DEPTH_LOG2+1  TX occupancy.
- err_underrun_cnt  out  16  count of rd_n low while RX empty; saturating.
- err_overrun_cnt  out  16  count of wr_n low while TX full (word dropped); saturating.
- err_proto_cnt  out  16  count of wr_n and oe_n both low; saturating.

Behaviour:
Reset and flush
- rst, or ft601_rst_n sampled low, flushes both FIFOs.
- Values while in reset:
  - ft601_rxf_n=1, ft601_txe_n=1.
  - ft601_data_oe=0, ft601_data_o=0, ft601_be_o=0.
  - host_tx_valid=0, host_rx_ready=0.
  - levels=0.
- Error counters are cleared by rst only, not by ft601_rst_n.
- Reset mid-burst discards in-flight words; no partial pop or push completes that cycle.

Bus state machine (registered): IDLE, RD_TURN, RD, WR.
- IDLE -> RD_TURN on oe_n=0.
- RD_TURN -> RD on the next cycle. ft601_data_oe rises on entering RD_TURN, one cycle after oe_n sampled low, modelling bus turnaround.
- RD -> IDLE on oe_n=1. ft601_data_oe falls in the same cycle IDLE is entered.
- IDLE -> WR on wr_n=0.
- WR -> IDLE on wr_n=1.
- wr_n=0 and oe_n=0 together: err_proto_cnt+1; no push and no pop; state stays/returns IDLE.

RX path (first-word-fall-through)
- ft601_data_o always holds the RX head word, registered. ft601_be_o=4'hF whenever RX is non-empty, else 0.
- ft601_rxf_n is a register equal to (RX level==0 after the current edge's update), so data_o and rxf_n stay consistent on every edge.
- Pop at an edge where state is RD_TURN or RD, rd_n=0 and rxf_n=0. The next word appears on data_o the following cycle.
- rd_n=0 while rxf_n=1: err_underrun_cnt+1, no pop.
- host_rx_ready = RX not full and not in reset. A push occurs when valid and ready are both high.
- Simultaneous push and pop is allowed; level is unchanged. A push into an empty FIFO becomes visible on data_o/rxf_n one cycle later.

TX path
- Push ft601_data_i at every edge where state is WR (or IDLE->WR entry), wr_n=0 and TX not full. ft601_be_i is ignored for storage.
- txe_n does not gate pushes: writes within the TXE_MARGIN window after txe_n rises are accepted.
- TX full with wr_n=0: word dropped, err_overrun_cnt+1.
- ft601_txe_n is registered: 1 when TX free entries <= TXE_MARGIN, else 0.
- host_tx_valid = TX non-empty; the word is popped when host_tx_ready=1.

Counters and levels
- Error counters saturate at 16'hFFFF.
- Levels are full-width with no wrap ambiguity: a full FIFO reports exactly 2^N.

Optional Feature:
FT601_EMU_LOOPBACK_EN
- Defined:
  - Each word pushed into TX is also pushed into RX in the same cycle, if RX is not full; otherwise it is dropped and err_overrun_cnt+1.
  - host_tx_valid is tied 0.
  - host_rx_ready is 0 during any cycle with a loopback push. Host injection has lower priority than loopback.
- Undefined: TX and RX are independent, as described above.

Test Plan:
1. Reset for 4 cycles, then release. Expect rxf_n=1, txe_n=1->0 one cycle after release, data_oe=0, all counters 0.
2. Inject 0x11111111, 0x22222222, 0x33333333 via host_rx; FPGA asserts oe_n=0, then rd_n=0 for 3 cycles. Expect data_oe high from the second cycle, 3 words read in order, rxf_n=1 after the third pop, err_underrun_cnt=0.
3. FPGA holds wr_n=0 for 1024 cycles with an incrementing data pattern, host_tx_ready=0, depth 1024. Expect txe_n=1 once tx_level=1020, tx_level=1024, err_overrun_cnt=0. A 1025th write gives err_overrun_cnt=1.
4. Assert wr_n=0 and oe_n=0 in the same cycle. Expect err_proto_cnt=1, tx_level and rx_level unchanged.
5. With RX holding 5 words, pulse ft601_rst_n low for 1 cycle. Expect rx_level=0, rxf_n=1 next cycle, error counters retained.
6. With FT601_EMU_LOOPBACK_EN defined, write 0xDEADBEEF. Expect rxf_n=0 and data_o=0xDEADBEEF two cycles later, host_tx_valid never 1.

Source files
------------

// File: rtl/pcileech_ft601_emu_if.sv
// FT601 245-synchronous FIFO bus bundle between the FPGA-side master
// (pcileech_com) and the device-side emulator.
//   master : FPGA side, drives data_i/be_i and the active-low strobes.
//   slave  : emulator side, drives data_o/data_oe/be_o and the rxf_n/txe_n flags.
interface pcileech_ft601_emu_if;
  logic [31:0] ft601_data_i;
  logic [31:0] ft601_data_o;
  logic        ft601_data_oe;
  logic [3:0]  ft601_be_i;
  logic [3:0]  ft601_be_o;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_rd_n;
  logic        ft601_oe_n;
  logic        ft601_wr_n;
  logic        ft601_rst_n;
  logic        ft601_siwu_n;

  modport master (
    output ft601_data_i, ft601_be_i, ft601_rd_n, ft601_oe_n, ft601_wr_n,
           ft601_rst_n, ft601_siwu_n,
    input  ft601_data_o, ft601_data_oe, ft601_be_o, ft601_rxf_n, ft601_txe_n
  );

  modport slave (
    input  ft601_data_i, ft601_be_i, ft601_rd_n, ft601_oe_n, ft601_wr_n,
           ft601_rst_n, ft601_siwu_n,
    output ft601_data_o, ft601_data_oe, ft601_be_o, ft601_rxf_n, ft601_txe_n
  );
endinterface

// File: rtl/pcileech_ft601_emu.sv
// Device-side FT601 245-synchronous FIFO emulator. Host valid/ready streams
// feed the RX FIFO (read by the FPGA) and drain the TX FIFO (written by it).
// Ports: clk, rst (sync, active high); host_rx_* in-stream; host_tx_* out-stream;
//   ft (pcileech_ft601_emu_if.slave) FT601 bus; rx_level/tx_level occupancy;
//   err_underrun_cnt/err_overrun_cnt/err_proto_cnt saturating error counters.
// Optional: define FT601_EMU_LOOPBACK_EN to mirror every TX push into RX.

// First-word-fall-through FIFO with registered head/empty/level.
module pcileech_ft601_emu_fifo #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                flush,
  input  logic                push,
  input  logic [31:0]         push_data,
  input  logic                pop,
  output logic [31:0]         head,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic [DEPTH_LOG2:0] level_next_c,
  output logic                full_c
);
  localparam int unsigned AW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic          do_push, do_pop;

  always_comb begin
    full_c       = (level == AW'(DEPTH));
    do_push      = push && !full_c;
    do_pop       = pop && !empty;
    wr_ptr_d     = wr_ptr_q + AW'(do_push);
    rd_ptr_d     = rd_ptr_q + AW'(do_pop);
    level_next_c = wr_ptr_d - rd_ptr_d;
  end

  // Head bypasses the array when the slot being written becomes the new head.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      empty    <= 1'b1;
      head     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level    <= level_next_c;
      empty    <= (level_next_c == '0);
      head     <= (do_push && (rd_ptr_d == wr_ptr_q)) ? push_data
                                                     : mem[rd_ptr_d[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
  end
endmodule

module pcileech_ft601_emu #(
  parameter int unsigned RX_DEPTH_LOG2 = 10,
  parameter int unsigned TX_DEPTH_LOG2 = 10,
  parameter int unsigned TXE_MARGIN    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            host_rx_data,
  input  logic                   host_rx_valid,
  output logic                   host_rx_ready,
  output logic [31:0]            host_tx_data,
  output logic                   host_tx_valid,
  input  logic                   host_tx_ready,
  pcileech_ft601_emu_if.slave    ft,
  output logic [RX_DEPTH_LOG2:0] rx_level,
  output logic [TX_DEPTH_LOG2:0] tx_level,
  output logic [15:0]            err_underrun_cnt,
  output logic [15:0]            err_overrun_cnt,
  output logic [15:0]            err_proto_cnt
);
  localparam int unsigned RXW      = RX_DEPTH_LOG2 + 1;
  localparam int unsigned TXW      = TX_DEPTH_LOG2 + 1;
  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RD_TURN, RD, WR} state_t;

  state_t          state_q, state_d;
  logic            flush_c, conflict_c;
  logic            rx_pop_c, tx_wr_req_c, tx_push_c;
  logic            underrun_c, overrun_c, proto_c;
  logic            host_push_c, lb_push_c, rx_push_c;
  logic [31:0]     rx_push_data_c;
  logic            rx_empty, rx_full_c, tx_empty, tx_full_c, tx_pop_c;
  logic [RXW-1:0]  rx_level_next_c;
  logic [TXW-1:0]  tx_level_next_c;
  logic [31:0]     rx_head;
  logic            data_oe_q, txe_n_q, rx_ready_q;
  logic [3:0]      be_q;
  logic            unused_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  assign flush_c = rst || !ft.ft601_rst_n;

  // Bus state machine; a wr_n/oe_n collision aborts everything back to IDLE.
  always_comb begin
    state_d     = state_q;
    tx_wr_req_c = 1'b0;
    rx_pop_c    = 1'b0;
    proto_c     = 1'b0;
    conflict_c  = !ft.ft601_wr_n && !ft.ft601_oe_n;
    unique case (state_q)
      IDLE: begin
        if (!ft.ft601_oe_n) begin
          state_d = RD_TURN;
        end else if (!ft.ft601_wr_n) begin
          state_d     = WR;
          tx_wr_req_c = 1'b1;
        end
      end
      RD_TURN: state_d = RD;
      RD:      if (ft.ft601_oe_n) state_d = IDLE;
      WR: begin
        if (ft.ft601_wr_n) state_d = IDLE;
        else               tx_wr_req_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == RD_TURN) || (state_q == RD)) rx_pop_c = !ft.ft601_rd_n;
    if (conflict_c) begin
      state_d     = IDLE;
      tx_wr_req_c = 1'b0;
      rx_pop_c    = 1'b0;
      proto_c     = !flush_c;
    end
    if (flush_c) state_d = IDLE;
  end

  // Datapath steering between the host stream, the bus and the FIFOs.
  always_comb begin
    tx_push_c   = tx_wr_req_c && !tx_full_c;
    underrun_c  = !flush_c && !ft.ft601_rd_n && rx_empty;
    overrun_c   = !flush_c && tx_wr_req_c && tx_full_c;
`ifdef FT601_EMU_LOOPBACK_EN
    lb_push_c     = tx_push_c && !rx_full_c;
    overrun_c     = overrun_c || (!flush_c && tx_push_c && rx_full_c);
    host_rx_ready = rx_ready_q && !lb_push_c;
    host_tx_valid = 1'b0;
`else
    lb_push_c     = 1'b0;
    host_rx_ready = rx_ready_q;
    host_tx_valid = !tx_empty;
`endif
    host_push_c    = host_rx_valid && host_rx_ready;
    rx_push_c      = lb_push_c || host_push_c;
    rx_push_data_c = lb_push_c ? ft.ft601_data_i : host_rx_data;
    tx_pop_c       = host_tx_valid && host_tx_ready;
  end

  pcileech_ft601_emu_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk          (clk),
    .flush        (flush_c),
    .push         (rx_push_c),
    .push_data    (rx_push_data_c),
    .pop          (rx_pop_c),
    .head         (rx_head),
    .empty        (rx_empty),
    .level        (rx_level),
    .level_next_c (rx_level_next_c),
    .full_c       (rx_full_c)
  );

  pcileech_ft601_emu_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk          (clk),
    .flush        (flush_c),
    .push         (tx_push_c),
    .push_data    (ft.ft601_data_i),
    .pop          (tx_pop_c),
    .head         (host_tx_data),
    .empty        (tx_empty),
    .level        (tx_level),
    .level_next_c (tx_level_next_c),
    .full_c       (tx_full_c)
  );

  // Bus-side registers, all flushed by either reset source.
  always_ff @(posedge clk) begin
    if (flush_c) begin
      state_q    <= IDLE;
      data_oe_q  <= 1'b0;
      be_q       <= 4'h0;
      txe_n_q    <= 1'b1;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_oe_q  <= (state_d == RD_TURN) || (state_d == RD);
      be_q       <= (rx_level_next_c != '0) ? 4'hF : 4'h0;
      txe_n_q    <= (TXW'(TX_DEPTH) - tx_level_next_c) <= TXW'(TXE_MARGIN);
      rx_ready_q <= (rx_level_next_c != RXW'(RX_DEPTH));
    end
  end

  // Error counters survive ft601_rst_n; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underrun_cnt <= '0;
      err_overrun_cnt  <= '0;
      err_proto_cnt    <= '0;
    end else begin
      err_underrun_cnt <= sat_inc(err_underrun_cnt, underrun_c);
      err_overrun_cnt  <= sat_inc(err_overrun_cnt, overrun_c);
      err_proto_cnt    <= sat_inc(err_proto_cnt, proto_c);
    end
  end

  assign ft.ft601_data_o  = rx_head;
  assign ft.ft601_data_oe = data_oe_q;
  assign ft.ft601_be_o    = be_q;
  assign ft.ft601_rxf_n   = rx_empty;
  assign ft.ft601_txe_n   = txe_n_q;

  assign unused_c = ^{ft.ft601_be_i, ft.ft601_siwu_n, rx_full_c, tx_empty};
endmodule

// File: tb/tb_pcileech_ft601_emu.sv
module tb_pcileech_ft601_emu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] host_rx_data;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [31:0] host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic [10:0] rx_level;
  logic [10:0] tx_level;
  logic [15:0] err_underrun_cnt, err_overrun_cnt, err_proto_cnt;

  int tests = 0;
  int fails = 0;

  pcileech_ft601_emu_if bus ();

  pcileech_ft601_emu dut (
    .clk              (clk),
    .rst              (rst),
    .host_rx_data     (host_rx_data),
    .host_rx_valid    (host_rx_valid),
    .host_rx_ready    (host_rx_ready),
    .host_tx_data     (host_tx_data),
    .host_tx_valid    (host_tx_valid),
    .host_tx_ready    (host_tx_ready),
    .ft               (bus.slave),
    .rx_level         (rx_level),
    .tx_level         (tx_level),
    .err_underrun_cnt (err_underrun_cnt),
    .err_overrun_cnt  (err_overrun_cnt),
    .err_proto_cnt    (err_proto_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] rd_exp [3];
    rd_exp[0] = 32'h11111111;
    rd_exp[1] = 32'h22222222;
    rd_exp[2] = 32'h33333333;

    rst               = 1'b1;
    host_rx_data      = '0;
    host_rx_valid     = 1'b0;
    host_tx_ready     = 1'b0;
    bus.ft601_data_i  = '0;
    bus.ft601_be_i    = 4'hF;
    bus.ft601_rd_n    = 1'b1;
    bus.ft601_oe_n    = 1'b1;
    bus.ft601_wr_n    = 1'b1;
    bus.ft601_rst_n   = 1'b1;
    bus.ft601_siwu_n  = 1'b1;

    // 1: reset values
    repeat (4) tick();
    check("rst_rxf_n", 32'(bus.ft601_rxf_n), 32'd1);
    check("rst_txe_n", 32'(bus.ft601_txe_n), 32'd1);
    check("rst_data_oe", 32'(bus.ft601_data_oe), 32'd0);
    check("rst_data_o", bus.ft601_data_o, 32'd0);
    check("rst_rx_ready", 32'(host_rx_ready), 32'd0);
    check("rst_tx_valid", 32'(host_tx_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_txe_n", 32'(bus.ft601_txe_n), 32'd0);
    check("rel_rxf_n", 32'(bus.ft601_rxf_n), 32'd1);
    check("rel_rx_ready", 32'(host_rx_ready), 32'd1);
    check("rel_counters", {err_underrun_cnt, err_overrun_cnt ^ err_proto_cnt}, 32'd0);
    check("rel_levels", {5'd0, rx_level, 5'd0, tx_level}, 32'd0);

    // 2: three host words read back over the bus
    host_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_rx_data = rd_exp[i];
      tick();
    end
    host_rx_valid = 1'b0;
    check("inj_rx_level", 32'(rx_level), 32'd3);
    check("inj_rxf_n", 32'(bus.ft601_rxf_n), 32'd0);
    check("inj_be_o", 32'(bus.ft601_be_o), 32'hF);
    bus.ft601_oe_n = 1'b0;
    check("turn_oe_low", 32'(bus.ft601_data_oe), 32'd0);
    tick();
    check("turn_oe_high", 32'(bus.ft601_data_oe), 32'd1);
    bus.ft601_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rd_word", bus.ft601_data_o, rd_exp[i]);
      tick();
    end
    check("rd_rxf_n_empty", 32'(bus.ft601_rxf_n), 32'd1);
    check("rd_rx_level", 32'(rx_level), 32'd0);
    check("rd_be_o", 32'(bus.ft601_be_o), 32'd0);
    check("rd_underrun", 32'(err_underrun_cnt), 32'd0);
    bus.ft601_rd_n = 1'b1;
    bus.ft601_oe_n = 1'b1;
    tick();
    check("rd_oe_fall", 32'(bus.ft601_data_oe), 32'd0);

    // underrun: read strobe with nothing queued
    bus.ft601_rd_n = 1'b0;
    tick();
    bus.ft601_rd_n = 1'b1;
    check("underrun_cnt", 32'(err_underrun_cnt), 32'd1);

    // 4: wr_n and oe_n collide
    bus.ft601_data_i = 32'hCAFEF00D;
    bus.ft601_wr_n   = 1'b0;
    bus.ft601_oe_n   = 1'b0;
    tick();
    bus.ft601_wr_n = 1'b1;
    bus.ft601_oe_n = 1'b1;
    check("proto_cnt", 32'(err_proto_cnt), 32'd1);
    check("proto_tx_level", 32'(tx_level), 32'd0);
    check("proto_rx_level", 32'(rx_level), 32'd0);
    tick();
    check("proto_oe_idle", 32'(bus.ft601_data_oe), 32'd0);

    // 5: ft601_rst_n flush with five words queued
    host_rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_rx_data = 32'hA0 + 32'(i);
      tick();
    end
    host_rx_valid = 1'b0;
    check("flush_pre_level", 32'(rx_level), 32'd5);
    bus.ft601_rst_n = 1'b0;
    tick();
    bus.ft601_rst_n = 1'b1;
    check("flush_rx_level", 32'(rx_level), 32'd0);
    check("flush_rxf_n", 32'(bus.ft601_rxf_n), 32'd1);
    check("flush_txe_n", 32'(bus.ft601_txe_n), 32'd1);
    check("flush_rx_ready", 32'(host_rx_ready), 32'd0);
    check("flush_keep_under", 32'(err_underrun_cnt), 32'd1);
    check("flush_keep_proto", 32'(err_proto_cnt), 32'd1);
    tick();
    check("flush_txe_n_rel", 32'(bus.ft601_txe_n), 32'd0);
    check("flush_rx_ready_rel", 32'(host_rx_ready), 32'd1);

`ifdef FT601_EMU_LOOPBACK_EN
    // 6: loopback of an FPGA write into RX
    bus.ft601_data_i = 32'hDEADBEEF;
    bus.ft601_wr_n   = 1'b0;
    #1;
    check("lb_rx_ready_low", 32'(host_rx_ready), 32'd0);
    tick();
    bus.ft601_wr_n = 1'b1;
    check("lb_tx_valid_0", 32'(host_tx_valid), 32'd0);
    check("lb_rx_level", 32'(rx_level), 32'd1);
    tick();
    check("lb_rxf_n", 32'(bus.ft601_rxf_n), 32'd0);
    check("lb_data_o", bus.ft601_data_o, 32'hDEADBEEF);
    check("lb_tx_valid_1", 32'(host_tx_valid), 32'd0);
`else
    // 3: fill TX to depth, watch txe_n margin, then overflow by one
    bus.ft601_wr_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      bus.ft601_data_i = 32'(i);
      tick();
      if (i == 1018) check("txe_n_before_margin", 32'(bus.ft601_txe_n), 32'd0);
      if (i == 1019) check("txe_n_at_margin", 32'(bus.ft601_txe_n), 32'd1);
    end
    check("fill_tx_level", 32'(tx_level), 32'd1024);
    check("fill_overrun", 32'(err_overrun_cnt), 32'd0);
    check("fill_tx_valid", 32'(host_tx_valid), 32'd1);
    check("fill_rx_level", 32'(rx_level), 32'd0);
    bus.ft601_data_i = 32'hFFFFFFFF;
    tick();
    bus.ft601_wr_n = 1'b1;
    check("over_cnt", 32'(err_overrun_cnt), 32'd1);
    check("over_tx_level", 32'(tx_level), 32'd1024);
    tick();
    host_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_word", host_tx_data, 32'(i));
      tick();
    end
    host_tx_ready = 1'b0;
    check("drain_tx_level", 32'(tx_level), 32'd1021);
    check("drain_txe_n", 32'(bus.ft601_txe_n), 32'd1);
    check("drain_head", host_tx_data, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
